// File: rtl/shifter8_pkg.sv
// Shared types for the shifter8 datapath.
// Op and state encodings, pass-size limit and pass helper.
package shifter8_pkg;

  localparam int WIDTH    = 8;
  localparam int MAX_PASS = 3;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // Largest amount the 2-bit stage can apply this clock.
  function automatic logic [1:0] pass_amt(
    input logic [2:0] rem
  );
    return (rem > 3'(MAX_PASS)) ? 2'(MAX_PASS)
                                : rem[1:0];
  endfunction

endpackage

// File: rtl/shift_seq8_if.sv
// Start/done request bundle for the sequenced shifter.
// Master issues operations, slave returns results.
interface shift_seq8_if;
  import shifter8_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [2:0]       shamt;
  logic [WIDTH-1:0] d_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d_out;

  modport master (
    output start, op, shamt, d_in,
    input  busy, done, d_out
  );

  modport slave (
    input  start, op, shamt, d_in,
    output busy, done, d_out
  );

endinterface

// File: rtl/shift_seq8_stage.sv
// Combinational 8-bit shift stage, amount 0..3.
// Left path in lsl8; right/rotate paths share one mx4 per bit.
module mx4 (
  input  logic [3:0] i_d,
  input  logic [1:0] i_sel,
  output logic       o_y
);
  assign o_y = i_d[i_sel];
endmodule

module lsl8 (
  input  logic [7:0] i_d,
  input  logic [1:0] i_sh,
  output logic [7:0] o_d
);
  logic [10:0] w_ext;

  assign w_ext = {i_d, 3'b000};

  for (genvar i = 0; i < 8; i++) begin : g_bit
    mx4 u_mx (
      .i_d   ({w_ext[i], w_ext[i+1],
               w_ext[i+2], w_ext[i+3]}),
      .i_sel (i_sh),
      .o_y   (o_d[i])
    );
  end
endmodule

module shift_stage8
  import shifter8_pkg::*;
(
  input  logic [7:0] i_d,
  input  op_t        i_op,
  input  logic [1:0] i_sh,
  output logic [7:0] o_d
);
  logic [7:0]  w_left;
  logic [7:0]  w_right;
  logic [10:0] w_ext;
  logic        w_fill;

  // Bits above the MSB: sign/zero fill, or the low bits for rotate.
  assign w_fill = (i_op == OP_ASR) & i_d[7];
  assign w_ext  = (i_op == OP_ROR)
                ? {i_d[2:0], i_d}
                : {{3{w_fill}}, i_d};

  lsl8 u_lsl (
    .i_d  (i_d),
    .i_sh (i_sh),
    .o_d  (w_left)
  );

  for (genvar i = 0; i < 8; i++) begin : g_r
    mx4 u_mx (
      .i_d   (w_ext[i+3:i]),
      .i_sel (i_sh),
      .o_y   (w_right[i])
    );
  end

  assign o_d = (i_op == OP_LSL) ? w_left
                                : w_right;
endmodule

// File: rtl/shift_seq8.sv
// Sequenced 8-bit shifter: splits 0..7 into passes of <=3,
// one pass per clock through shift_stage8, with start/done.
module shift_seq8
  import shifter8_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  shift_seq8_if.slave  bus
);
  state_t     r_state;
  logic [7:0] r_data;
  logic [7:0] r_dout;
  logic [2:0] r_rem;
  op_t        r_opr;
  logic       r_done;

  logic [1:0] w_pass;
  logic [7:0] w_stage;
  logic       w_last;

  assign w_pass = pass_amt(r_rem);
  assign w_last = (r_rem <= 3'(MAX_PASS));

  shift_stage8 u_stage (
    .i_d  (r_data),
    .i_op (r_opr),
    .i_sh (w_pass),
    .o_d  (w_stage)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_rem   <= '0;
      r_opr   <= OP_LSL;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_data  <= bus.d_in;
            r_opr   <= op_t'(bus.op);
            r_rem   <= bus.shamt;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data <= w_stage;
          r_rem  <= r_rem - {1'b0, w_pass};
          // Last pass: publish the result as DONE is entered.
          if (w_last) begin
            r_dout  <= w_stage;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = r_done;
  assign bus.d_out = r_dout;

endmodule

// File: tb/tb_shift_seq8.sv
// Scoreboard bench for shift_seq8: driver queues expected
// results, a negedge monitor checks them on each done pulse.
module tb_shift_seq8;

  typedef struct {
    logic [7:0] d;
    int         cyc;
    string      nm;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  exp_t e;

  shift_seq8_if bus ();

  shift_seq8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done got=%h want=none",
                 bus.d_out);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_dout"}, bus.d_out, e.d);
        n_vec++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL %s_latency got=%0d want=%0d",
                   e.nm, cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [2:0] sh,
                       input logic [7:0] d,
                       input logic [7:0] exp,
                       input int p,
                       input bit track,
                       input string nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.shamt = sh;
    bus.d_in  = d;
    if (track)
      sb.push_back('{d: exp, cyc: cyc + 1 + p, nm: nm});
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.shamt = 3'($urandom);
    bus.d_in  = 8'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [2:0] sh,
                        input logic [7:0] d,
                        input logic [7:0] exp,
                        input int p,
                        input string nm);
    issue(op, sh, d, exp, p, 1'b1, nm);
    chk({nm, "_busy"}, 8'(bus.busy), 8'h01);
    repeat (p) begin
      @(negedge clk);
      chk({nm, "_busy"}, 8'(bus.busy), 8'h01);
    end
    @(negedge clk);
    chk({nm, "_idle"}, 8'(bus.busy), 8'h00);
  endtask

  logic [7:0] hv [9];
  logic [7:0] he [3];

  initial begin
    n_vec = 0;
    n_bad = 0;
    hv = '{8'h3C, 8'hC3, 8'h3C, 8'hA5, 8'h5A,
           8'hA5, 8'h0F, 8'hF0, 8'h0F};
    he = '{8'h78, 8'h4A, 8'h1E};
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.shamt = 3'd0;
    bus.d_in  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 8'(bus.busy), 8'h00);
    chk("rst_done", 8'(bus.done), 8'h00);
    chk("rst_dout", bus.d_out, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 3'd5, 8'hB5, 8'hA0, 2, "lsl_b5_5");
    run_op(2'b10, 3'd7, 8'h90, 8'hFF, 3, "asr_90_7");
    run_op(2'b10, 3'd7, 8'h70, 8'h00, 3, "asr_70_7");
    run_op(2'b01, 3'd3, 8'h90, 8'h12, 1, "lsr_90_3");
    run_op(2'b11, 3'd4, 8'h81, 8'h18, 2, "ror_81_4");
    run_op(2'b00, 3'd0, 8'h5A, 8'h5A, 1, "lsl_5a_0");
    run_op(2'b11, 3'd7, 8'h81, 8'h03, 3, "ror_81_7");
    run_op(2'b10, 3'd2, 8'h84, 8'hE1, 1, "asr_84_2");

    // start held high: accepts only every third edge
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.shamt = 3'd1;
      bus.d_in  = hv[j];
      if (j % 3 == 0) begin
        chk("held_idle", 8'(bus.busy), 8'h00);
        sb.push_back('{d: he[j/3], cyc: cyc + 2,
                       nm: "held"});
      end else begin
        chk("held_busy", 8'(bus.busy), 8'h01);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // start pulse during SHIFT is ignored
    issue(2'b00, 3'd7, 8'h01, 8'h80, 3, 1'b1, "ignore");
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.shamt = 3'd0;
    bus.d_in  = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignore_hold", bus.d_out, 8'h80);
    chk("ignore_idle", 8'(bus.busy), 8'h00);

    // reset in second SHIFT cycle aborts silently
    issue(2'b00, 3'd7, 8'h01, 8'h80, 3, 1'b0, "abort");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 8'(bus.busy), 8'h00);
    chk("abort_done", 8'(bus.done), 8'h00);
    chk("abort_dout", bus.d_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_dout", bus.d_out, 8'h00);
    chk("post_rst_busy", 8'(bus.busy), 8'h00);

    run_op(2'b11, 3'd1, 8'h81, 8'hC0, 1, "ror_81_1");
    repeat (2) @(negedge clk);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
